// File: rtl/pipe_stage_skid_pkg.sv
// ============================================================================
// Module : pipe_stage_skid_pkg
// Brief  : Shared constants and state encoding for the skid-buffered stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stage_skid_pkg;

  localparam logic [15:0] NOP_BUBBLE = 16'h1000;
  localparam int          OCC_W      = 2;

  // Encoded so that the state value is the number of held entries.
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    return OCC_W'(s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module : pipe_reg_n
// Brief  : Parametrised register with write enable and sync reset value.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_n #(
  parameter int              W       = 16,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module : pipe_stage_skid
// Brief  : Ready/valid pipeline stage with 2-entry skid, flush and bubble count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_BUBBLE),
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [CNT_W-1:0]    bubble_cnt_q;
  logic                accept, emit;
  logic                main_we, skid_we;
  logic [DATA_W-1:0]   main_d, main_q, skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  // main is reloaded with BUBBLE whenever the stage drains, so out_data is
  // never stale while empty.
  always_comb begin
    state_d = state_q;
    main_we = 1'b0;
    main_d  = in_data;
    skid_we = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      main_we = 1'b1;
      main_d  = BUBBLE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_we = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_we = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_we = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
            main_we = 1'b1;
            main_d  = BUBBLE;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d = ST_ONE;
            main_we = 1'b1;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_we = 1'b1;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (out_ready && !out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  pipe_reg_n #(
    .W       (DATA_W),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .we_i (main_we),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  pipe_reg_n #(
    .W       (DATA_W),
    .RST_VAL (BUBBLE)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .we_i (skid_we),
    .d_i  (in_data),
    .q_o  (skid_q)
  );

  assign in_ready   = in_ready_q;
  assign out_data   = main_q;
  assign occupancy  = occ_of(state_q);
  assign bubble_cnt = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module : tb_pipe_stage_skid
// Brief  : Self-checking bench for pipe_stage_skid against a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

  localparam logic [15:0] BUB = 16'h1000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_occupancy;
  logic [2:0]  b_bubble_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the stage is a FIFO of at most two entries.
  logic [15:0] mq[$];
  logic        m_in_ready;
  int          m_cnt;
  int          m_cnt3;

  pipe_stage_skid #(.DATA_W(16), .BUBBLE(16'h1000), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(16), .BUBBLE(16'h1000), .CNT_W(3)) dut_c3 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_data   (b_out_data),
    .occupancy  (b_occupancy),
    .bubble_cnt (b_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : BUB;
    check("out_valid",  32'(out_valid),    32'(mq.size() != 0));
    check("out_data",   32'(out_data),     32'(exp_data));
    check("occupancy",  32'(occupancy),    32'(mq.size()));
    check("in_ready",   32'(in_ready),     32'(m_in_ready));
    check("bubble_cnt", 32'(bubble_cnt),   32'(m_cnt));
    check("bubble_c3",  32'(b_bubble_cnt), 32'(m_cnt3));
    check("c3_data",    32'(b_out_data),   32'(exp_data));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_in_ready = 1'b1;
    m_cnt  = 0;
    m_cnt3 = 0;
    check_outputs();
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then compare.
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    logic acc, emt;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    check("in_ready_no_comb", 32'(in_ready), 32'(m_in_ready));
    acc = iv & m_in_ready;
    emt = (mq.size() != 0) & ordy;
    if (ordy && mq.size() == 0) begin
      if (m_cnt  < 65535) m_cnt++;
      if (m_cnt3 < 7)     m_cnt3++;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    m_in_ready = (mq.size() < 2);
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    m_in_ready = 1'b1; m_cnt = 0; m_cnt3 = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_data_const", 32'(out_data), 32'h1000);

    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    check("idle_cnt_const", 32'(bubble_cnt), 32'd3);

    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

    step(1'b1, 16'hA0A0, 1'b0, 1'b0);
    step(1'b1, 16'hB0B0, 1'b0, 1'b0);
    check("skid_full_occ", 32'(occupancy), 32'd2);
    check("skid_full_rdy", 32'(in_ready),  32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("skid_hold_A",   32'(out_data),  32'hA0A0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("after_A_B",     32'(out_data),  32'hB0B0);
    check("after_A_rdy",   32'(in_ready),  32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'hCCCC, 1'b0, 1'b1);
    check("flush_data", 32'(out_data),  32'h1000);
    check("flush_occ",  32'(occupancy), 32'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    check("cnt3_sat", 32'(b_bubble_cnt), 32'd7);
    do_reset();

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           16'($urandom),
           ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0);
      if (i == 5000) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
